// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
//
// Shares one N-bit enable/reset register among R requesters. A round-robin
// arbiter picks one requester in IDLE, then every write runs through the fixed
// sequence WRITE -> CHECK -> ACK: one cycle of register enable, one cycle to
// read Q back and compare it with the written data, one cycle of ack.
//
// Handshake: a requester raises i_req[i] and holds it (and its i_wdata slot)
// until it sees o_ack[i] for one cycle. Requests and data are sampled only in
// IDLE; later changes do not affect a write already in flight. Dropping
// i_req mid-write does not abort it, and the ack still pulses.
//
// Ports
//   i_clock      rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_req        per-requester write request
//   i_wdata      packed write data, requester i at [i*N +: N]
//   o_gnt        one-hot owner marker during WRITE/CHECK/ACK
//   o_ack        one-cycle pulse to the owner when its write is done
//   o_err        readback mismatch, valid only in the ack cycle
//   o_rdata      Q value captured in CHECK, held until the next CHECK
//   o_reg_d      register D input (latched write data)
//   o_reg_en     register enable, high for exactly one cycle per write
//   i_reg_q      register Q output
//   o_busy       high whenever the FSM is not in IDLE
//   o_owner      index of the current or last granted requester
//   o_dbg_state  FSM state for observation (0 IDLE, 1 WRITE, 2 CHECK, 3 ACK)
// -----------------------------------------------------------------------------
module reg_access_arbiter #(
  parameter int N   = 32,
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic           i_clock,
  input  logic           i_rst_n,
  input  logic [R-1:0]   i_req,
  input  logic [R*N-1:0] i_wdata,
  output logic [R-1:0]   o_gnt,
  output logic [R-1:0]   o_ack,
  output logic           o_err,
  output logic [N-1:0]   o_rdata,
  output logic [N-1:0]   o_reg_d,
  output logic           o_reg_en,
  input  logic [N-1:0]   i_reg_q,
  output logic           o_busy,
  output logic [IDW-1:0] o_owner,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CHECK = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_owner;
  logic [N-1:0]   r_data;
  logic [N-1:0]   r_rdata;
  logic           r_mismatch;

  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [IDW:0]   w_j;
  logic [IDW-1:0] w_next_ptr;
  logic [N-1:0]   w_pick_data;
  logic [R-1:0]   w_owner_oh;

  // Round-robin search: walk R slots starting at the pointer. w_j carries one
  // spare bit so ptr + k never overflows before the modulo-R wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = '0;
    for (int k = 0; k < R; k++) begin
      w_j = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_j >= (IDW+1)'(R)) begin
        w_j = w_j - (IDW+1)'(R);
      end
      if (!w_found && i_req[w_j[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_j[IDW-1:0];
      end
    end
  end

  assign w_next_ptr = (w_pick == IDW'(R-1)) ? '0 : w_pick + 1'b1;

  // Select the winner's data slot with constant part-selects only.
  always_comb begin
    w_pick_data = '0;
    for (int k = 0; k < R; k++) begin
      if (IDW'(k) == w_pick) begin
        w_pick_data = i_wdata[k*N +: N];
      end
    end
  end

  assign w_owner_oh = {{(R-1){1'b0}}, 1'b1} << r_owner;

  // State register
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_CHECK;
      S_CHECK: w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_gnt    = '0;
    o_ack    = '0;
    o_err    = 1'b0;
    o_reg_en = 1'b0;
    o_busy   = (r_state != S_IDLE);
    case (r_state)
      S_WRITE: begin
        o_gnt    = w_owner_oh;
        o_reg_en = 1'b1;
      end
      S_CHECK: o_gnt = w_owner_oh;
      S_ACK: begin
        o_gnt = w_owner_oh;
        o_ack = w_owner_oh;
        o_err = r_mismatch;
      end
      default: ;
    endcase
  end

  // Datapath: grant latch in IDLE, readback capture in CHECK. r_data doubles
  // as the register D drive, so reg_d holds its last value outside WRITE.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_data     <= '0;
      r_rdata    <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_owner <= w_pick;
        r_data  <= w_pick_data;
        r_ptr   <= w_next_ptr;
      end
      if (r_state == S_CHECK) begin
        r_rdata    <= i_reg_q;
        r_mismatch <= (i_reg_q != r_data);
      end
    end
  end

  assign o_reg_d     = r_data;
  assign o_rdata     = r_rdata;
  assign o_owner     = r_owner;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;

  localparam int N   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [R-1:0]   req;
  logic [R*N-1:0] wdata;
  logic [N-1:0]   mask;
  logic [N-1:0]   reg_q = '0;

  logic [R-1:0]   gnt, ack;
  logic           err, reg_en, busy;
  logic [N-1:0]   rdata, reg_d;
  logic [IDW-1:0] owner;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  reg_access_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
    .i_clock    (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_wdata    (wdata),
    .o_gnt      (gnt),
    .o_ack      (ack),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_reg_d    (reg_d),
    .o_reg_en   (reg_en),
    .i_reg_q    (reg_q),
    .o_busy     (busy),
    .o_owner    (owner),
    .o_dbg_state(dbg_state)
  );

  // Shared register; mask models stuck-at-0 bits.
  always @(posedge clk) begin
    if (reg_en) reg_q <= reg_d & mask;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase counts cycles since the grant (0 = no write in flight).
  int           m_phase, m_ptr, m_owner;
  logic [N-1:0] m_data, m_q, m_rdata;
  bit           m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_owner = 0;
      m_data = '0; m_q = '0; m_rdata = '0; m_mis = 0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          bit found;
          found = 0;
          for (int k = 0; k < R; k++) begin
            int j;
            j = (m_ptr + k) % R;
            if (!found && req[j]) begin
              found = 1;
              m_owner = j;
            end
          end
          m_data  = wdata[m_owner*N +: N];
          m_ptr   = (m_owner + 1) % R;
          m_phase = 1;
        end
        1: begin m_q = m_data & mask; m_phase = 2; end
        2: begin m_rdata = m_q; m_mis = (m_q != m_data); m_phase = 3; end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [R-1:0] oh;
    oh = R'(1) << m_owner;
    chk("gnt",    gnt,    (m_phase != 0) ? oh : '0);
    chk("ack",    ack,    (m_phase == 3) ? oh : '0);
    chk("err",    err,    (m_phase == 3) && m_mis);
    chk("reg_en", reg_en, m_phase == 1);
    chk("busy",   busy,   m_phase != 0);
    chk("reg_d",  reg_d,  m_data);
    chk("rdata",  rdata,  m_rdata);
    chk("owner",  owner,  m_owner);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_wait();
    req = '0;
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic reset_with(input logic [R-1:0] r);
    rst_n = 1'b0;
    req   = r;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Single isolated write; call at posedge+2 with the DUT idle.
  task automatic do_single(input int idx, input logic [N-1:0] data,
                           input logic [N-1:0] exp_rd, input bit exp_err);
    req = '0;
    req[idx] = 1'b1;
    wdata[idx*N +: N] = data;
    @(posedge clk); #1;
    chk("single_reg_en", reg_en, 1);
    chk("single_reg_d", reg_d, data);
    chk("single_gnt", gnt, R'(1) << idx);
    @(posedge clk);
    @(posedge clk); #1;
    chk("single_ack", ack, R'(1) << idx);
    chk("single_rdata", rdata, exp_rd);
    chk("single_err", err, exp_err);
    req = '0;
    @(posedge clk); #1;
    chk("single_idle_busy", busy, 0);
    chk("single_reg_d_hold", reg_d, data);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt0, cnt2;
    logic [R-1:0] e;
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    mask  = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_en", reg_en, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_d", reg_d, 0);
    #1 rst_n = 1'b1;

    // Single write of 0xA5 from requester 0.
    do_single(0, 32'h0000_00A5, 32'h0000_00A5, 1'b0);

    // All four requesting from reset release: owners 0,1,2,3.
    reset_with(4'b1111);
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      e = (n % 4 == 3) ? (R'(1) << ((n - 3) / 4)) : '0;
      chk("rr_all_ack", ack, e);
      if (n == 15) req = '0;
    end
    #1;
    idle_wait();

    // 1010 held: owners alternate 1,3 and requesters 0/2 are never acked.
    reset_with(4'b1010);
    cnt0 = 0; cnt2 = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      e = (n % 4 == 3) ? (((n / 4) % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      chk("rr_alt_ack", ack, e);
      if (ack[0]) cnt0++;
      if (ack[2]) cnt2++;
      if (n == 15) req = '0;
    end
    chk("rr_alt_ack0_count", cnt0, 0);
    chk("rr_alt_ack2_count", cnt2, 0);
    #1;
    idle_wait();

    // Negative value passes through unchanged.
    do_single(2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);

    // Bit 0 stuck at 0: readback 0x2, err flagged.
    mask = 32'hFFFF_FFFE;
    do_single(0, 32'h0000_0003, 32'h0000_0002, 1'b1);
    mask = '1;
    idle_wait();

    // Reset during CHECK: outputs clear at once, then requester 0 wins first.
    req = 4'b0001;
    wdata[0 +: N] = 32'h0000_0055;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_ack", ack, 0);
    chk("async_err", err, 0);
    chk("async_rdata", rdata, 0);
    chk("async_reg_d", reg_d, 0);
    chk("async_reg_en", reg_en, 0);
    chk("async_busy", busy, 0);
    chk("async_owner", owner, 0);
    req = 4'b0101;
    wdata[2*N +: N] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_gnt", gnt, 4'b0001);
    chk("post_rst_owner", owner, 0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("post_rst_ack", ack, 4'b0001);
    req = '0;
    #1;
    idle_wait();

    // Randomised traffic; data and the stuck-bit mask change freely.
    repeat (400) begin
      @(posedge clk); #2;
      for (int i = 0; i < R; i++) begin
        if (ack[i])                          req[i] = ($urandom_range(0, 2) == 0);
        else if (!req[i])                    req[i] = ($urandom_range(0, 4) == 0);
        else if ($urandom_range(0, 30) == 0) req[i] = 1'b0;
        wdata[i*N +: N] = $urandom;
      end
      if ($urandom_range(0, 9) == 0)
        mask = ($urandom_range(0, 1) == 1) ? '1 : ~(32'(1) << $urandom_range(0, 31));
    end
    idle_wait();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
